// File: rtl/dualport_ram_be.sv
// Simple dual-port RAM with byte write enables, a clear-on-reset sequence and selectable read-during-write policy.
// Define DUALPORT_RAM_BE_OUTREG_EN to add a second output register stage (read latency 2 instead of 1).
module dualport_ram_be #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned RD_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     init_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = WIDTH / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [AW-1:0]     clr_cnt_q;
  logic [AW-1:0]     clr_cnt_d;
  logic              clr_we;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  old_word;
  logic [WIDTH-1:0]  rd_word;
  logic [WIDTH-1:0]  s1_data;
  logic              s1_valid;

  logic [WIDTH-1:0]  mem [DEPTH];

  // State and clear-counter registers; init_busy tracks the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      init_busy <= (state_d == CLEAR);
    end
  end

  // Next-state logic: sweep every address once, then serve user traffic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Request qualification; addresses past DEPTH exist only when DEPTH is not a power of two
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < (AW + 1)'(DEPTH));
    rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));
    wr_acc      = (state_q == IDLE) && !rst && wr_en && wr_in_range;
    rd_acc      = (state_q == IDLE) && !rst && rd_en;
  end

  // Read word, optionally forwarding the bytes being written this cycle
  always_comb begin
    old_word = rd_in_range ? mem[rd_addr] : '0;
    rd_word  = old_word;
    if ((RD_MODE == 1) && wr_acc && (wr_addr == rd_addr)) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (wr_be[b]) begin
          rd_word[8*b +: 8] = din[8*b +: 8];
        end
      end
    end
  end

  // Storage array: clear sweep has priority, user writes are byte-masked
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_cnt_q] <= '0;
      end else if (wr_acc) begin
        for (int b = 0; b < int'(BW); b++) begin
          if (wr_be[b]) begin
            mem[wr_addr][8*b +: 8] <= din[8*b +: 8];
          end
        end
      end
    end
  end

  // First output stage; data holds when no read is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

`ifdef DUALPORT_RAM_BE_OUTREG_EN
  logic [WIDTH-1:0] s2_data;
  logic             s2_valid;

  // Optional retiming stage, fully pipelined behind stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s1_data;
      end
    end
  end

  assign dout       = s2_data;
  assign dout_valid = s2_valid;
`else
  assign dout       = s1_data;
  assign dout_valid = s1_valid;
`endif

endmodule

// File: tb/tb_dualport_ram_be.sv
// Bench for dualport_ram_be: two instances (DEPTH 16 read-first, DEPTH 12 write-first) share one random stimulus
// and are checked every cycle against an array-based model, plus directed literal checks.
module tb_dualport_ram_be;

`ifdef DUALPORT_RAM_BE_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [3:0]  wr_addr;
  logic [31:0] din;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] dout0, dout1;
  logic        v0, v1, b0, b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dualport_ram_be #(.WIDTH(32), .DEPTH(16), .RD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout0), .dout_valid(v0), .init_busy(b0));

  dualport_ram_be #(.WIDTH(32), .DEPTH(12), .RD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .din(din),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout1), .dout_valid(v1), .init_busy(b1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pat(input int a);
    return 32'(a) * 32'h01010101 ^ 32'h80402010;
  endfunction

  // Behavioural model: word arrays, a clear countdown and an L-deep result pipe
  logic [31:0] mm [2][16];
  int          clr_left [2];
  logic        e_busy [2];
  logic        e_v [2];
  logic [31:0] e_d [2];
  logic        s_v [2];
  logic [31:0] s_d [2];
  bit          started = 1'b0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = 0; e_busy[k] = 1'b1; e_v[k] = 1'b0; e_d[k] = '0; s_v[k] = 1'b0; s_d[k] = '0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int          dep;
        int          mode;
        logic        nv;
        logic [31:0] nd;
        dep  = (k == 0) ? 16 : 12;
        mode = k;
        if (rst) begin
          started = 1'b1;
          for (int a = 0; a < 16; a++) mm[k][a] = '0;
          clr_left[k] = dep;
          e_busy[k] = 1'b1; e_v[k] = 1'b0; e_d[k] = '0; s_v[k] = 1'b0; s_d[k] = '0;
        end else begin
          nv = 1'b0;
          nd = '0;
          if (clr_left[k] > 0) begin
            clr_left[k]--;
          end else begin
            if (rd_en) begin
              nv = 1'b1;
              nd = (int'(rd_addr) < dep) ? mm[k][rd_addr] : 32'h0;
              if (mode == 1 && wr_en && wr_addr == rd_addr && int'(rd_addr) < dep) nd = merge(nd, din, wr_be);
            end
            if (wr_en && int'(wr_addr) < dep) mm[k][wr_addr] = merge(mm[k][wr_addr], din, wr_be);
          end
          e_busy[k] = (clr_left[k] > 0);
          if (L == 2) begin
            e_v[k] = s_v[k];
            if (s_v[k]) e_d[k] = s_d[k];
            s_v[k] = nv;
            if (nv) s_d[k] = nd;
          end else begin
            e_v[k] = nv;
            if (nv) e_d[k] = nd;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("valid0", 32'(v0), 32'(e_v[0]));
        chk("busy0",  32'(b0), 32'(e_busy[0]));
        chk("dout0",  dout0,   e_d[0]);
        chk("valid1", 32'(v1), 32'(e_v[1]));
        chk("busy1",  32'(b1), 32'(e_busy[1]));
        chk("dout1",  dout1,   e_d[1]);
      end
    end
  end

  task automatic idle_in();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; din = d; wr_be = be;
    cyc();
    idle_in();
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
    rd_en = 1'b1; rd_addr = a;
    cyc();
    idle_in();
    repeat (L - 1) cyc();
    chk("lit_valid0", 32'(v0), 32'd1);
    chk("lit_dout0", dout0, e0);
    chk("lit_valid1", 32'(v1), 32'd1);
    chk("lit_dout1", dout1, e1);
  endtask

  task automatic reset_and_count(input string tag);
    int c0, c1;
    c0 = 0; c1 = 0;
    rst = 1'b1; rd_en = 1'b1; wr_en = 1'b1;
    cyc();
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (b0) c0++;
      if (b1) c1++;
      rd_addr = 4'($urandom_range(0, 15));
      cyc();
    end
    idle_in();
    chk({tag, "_busy_len0"}, 32'(c0), 32'd16);
    chk({tag, "_busy_len1"}, 32'(c1), 32'd12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, first, last;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; wr_addr = '0; rd_addr = '0; din = '0;
    cyc(); cyc();

    reset_and_count("reset");
    chk("reset_dout0", dout0, 32'h0);
    for (int a = 0; a < 16; a++) rd_chk(4'(a), 32'h0, 32'h0);

    for (int a = 0; a < 16; a++) wr(4'(a), pat(a), 4'hF);

    // Streaming reads of 0..15 back to back
    vc = 0; first = -1; last = -1;
    for (int i = 0; i < 17 + L; i++) begin
      if (i < 16) begin rd_en = 1'b1; rd_addr = 4'(i); end
      else rd_en = 1'b0;
      cyc();
      if (v0) begin
        if (first < 0) first = i;
        last = i;
        chk("stream_data0", dout0, pat(vc));
        vc++;
      end
    end
    idle_in();
    chk("stream_count", 32'(vc), 32'd16);
    chk("stream_first", 32'(first), 32'(L - 1));
    chk("stream_last", 32'(last), 32'(L + 14));

    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd_chk(4'd3, 32'hAA22CC44, 32'hAA22CC44);

    // Same-cycle read and write to address 5
    wr(4'd5, 32'h0, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd5; din = 32'hFFFFFFFF; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 4'd5;
    cyc();
    idle_in();
    repeat (L - 1) cyc();
    chk("collide_rdfirst", dout0, 32'h00000000);
    chk("collide_wrfirst", dout1, 32'h0000FFFF);
    rd_chk(4'd5, 32'h0000FFFF, 32'h0000FFFF);

    wr(4'd13, 32'h12345678, 4'hF);
    rd_chk(4'd13, 32'h12345678, 32'h0);
    for (int a = 0; a < 12; a++) begin
      logic [31:0] e;
      e = (a == 3) ? 32'hAA22CC44 : (a == 5) ? 32'h0000FFFF : pat(a);
      rd_chk(4'(a), e, e);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      din     = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      cyc();
    end
    idle_in();
    repeat (20) cyc();

    // Reset restarted in the middle of a clear
    rst = 1'b1;
    cyc();
    rst = 1'b0; rd_en = 1'b1;
    repeat (7) cyc();
    reset_and_count("midclear");
    rd_chk(4'd0, 32'h0, 32'h0);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dualport_ram_be.md
DUALPORT_RAM_BE -- requirements
Module: dualport_ram_be

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; integer multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16, number of words; any value >= 2, need not be a power of two.
REQ-003 SHALL have parameter RD_MODE, default 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port wr_be  input  WIDTH/8  byte write enables; bit i covers din[8i+7:8i].
REQ-008 SHALL have port wr_addr  input  $clog2(DEPTH)  write address.
REQ-009 SHALL have port din  input  WIDTH  write data.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port rd_addr  input  $clog2(DEPTH)  read address.
REQ-012 SHALL have port dout  output  WIDTH  read data, registered.
REQ-013 SHALL have port dout_valid  output  1  one-cycle pulse marking dout as the result of an accepted read.
REQ-014 SHALL have port init_busy  output  1  high while the memory-clear sequence runs.

Function
REQ-015 SHALL contain a two-state FSM, CLEAR and IDLE, plus a clear counter of $clog2(DEPTH) bits.
REQ-016 In CLEAR, SHALL write all-zero to mem[counter] each cycle and increment the counter; after writing address DEPTH-1, SHALL go to IDLE on the next edge. Clear takes exactly DEPTH cycles.
REQ-017 init_busy SHALL equal 1 in CLEAR and 0 in IDLE.
REQ-018 In CLEAR, wr_en and rd_en SHALL be ignored: no user write occurs, and dout_valid stays 0.
REQ-019 In IDLE, a write with wr_en=1 SHALL update only the bytes whose wr_be bit is 1; wr_be=0 SHALL leave the word unchanged.
REQ-020 In IDLE, a read with rd_en=1 SHALL present mem[rd_addr] on dout with dout_valid=1 exactly 1 cycle later (base latency L=1).
REQ-021 When rd_en=0, dout SHALL hold its last value and dout_valid SHALL be 0 one cycle later.
REQ-022 For a same-cycle read and write to the same address with RD_MODE=0, the read SHALL return the pre-write word.
REQ-023 For the same case with RD_MODE=1, the read SHALL return the merged word: enabled bytes from din, other bytes from the old word.
REQ-024 A write to an address >= DEPTH SHALL be discarded.
REQ-025 A read from an address >= DEPTH SHALL return all-zero with dout_valid=1.
REQ-026 Back-to-back reads SHALL sustain one result per cycle with no bubbles.

Reset
REQ-027 On a cycle with rst=1, the FSM SHALL enter CLEAR and the counter SHALL load 0.
REQ-028 On a cycle with rst=1, dout SHALL reset to 0, dout_valid to 0, init_busy to 1, and all pipeline valid bits to 0.
REQ-029 Reset asserted during CLEAR or IDLE SHALL restart the clear from address 0.
REQ-030 Reset SHALL discard in-flight reads; no dout_valid SHALL appear for reads issued before reset.
REQ-031 A write presented in the same cycle as rst=1 SHALL NOT take effect.

Configuration
REQ-032 Macro DUALPORT_RAM_BE_OUTREG_EN, when defined, SHALL add a second output register stage, giving L=2.
REQ-033 With the macro defined, dout and dout_valid SHALL be delayed one further cycle, reset to 0, and remain fully pipelined.
REQ-034 With the macro undefined, L SHALL be 1. All other behaviour SHALL be identical in both builds.

Verification
REQ-035 Reset scenario: rst high 1 cycle with DEPTH=16 -> init_busy high for exactly 16 cycles; every subsequent read returns 0x00000000.
REQ-036 Byte-enable scenario: write 0xAABBCCDD with wr_be=4'b1111 to addr 3, then 0x11223344 with wr_be=4'b0101 -> read addr 3 gives 0xAA22CC44 after L cycles.
REQ-037 Collision scenario: mem[5]=0x0; same cycle write 0xFFFFFFFF with wr_be=4'b0011 and read addr 5 -> RD_MODE=0 returns 0x00000000; RD_MODE=1 returns 0x0000FFFF.
REQ-038 Out-of-range scenario: DEPTH=12, write 0x12345678 to addr 13 -> read addr 13 returns 0x0 with dout_valid=1; addresses 0-11 unchanged.
REQ-039 Reset mid-clear: rst pulsed at clear cycle 7 -> init_busy stays high for 16 further cycles; reads issued during CLEAR produce no dout_valid.
REQ-040 Streaming scenario: reads of addr 0..15 on consecutive cycles -> 16 consecutive dout_valid pulses in order, starting L cycles after the first rd_en, for both macro settings.
